// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks a red/green/yellow lamp sequence for encoding, order and dwell violations
module traffic_light_monitor #(
    parameter int RED_MIN = 2,
    parameter int RED_MAX = 8,
    parameter int GRN_MIN = 2,
    parameter int GRN_MAX = 8,
    parameter int YEL_MIN = 1,
    parameter int YEL_MAX = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        RED    = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_GRN = 3'b010;
    localparam logic [2:0] LAMP_YEL = 3'b001;

    localparam logic [8:0] R_MIN = 9'(RED_MIN);
    localparam logic [8:0] R_MAX = 9'(RED_MAX);
    localparam logic [8:0] G_MIN = 9'(GRN_MIN);
    localparam logic [8:0] G_MAX = 9'(GRN_MAX);
    localparam logic [8:0] Y_MIN = 9'(YEL_MIN);
    localparam logic [8:0] Y_MAX = 9'(YEL_MAX);

    localparam logic [2:0] CODE_ILLEGAL = 3'd1;
    localparam logic [2:0] CODE_ORDER   = 3'd2;
    localparam logic [2:0] CODE_SHORT   = 3'd3;
    localparam logic [2:0] CODE_LONG    = 3'd4;

    state_t     state, state_nxt;
    logic [7:0] dwell, dwell_nxt, dwell_inc;
    logic [2:0] prev;
    logic       first_red, first_red_nxt;
    logic       fault;
    logic [2:0] code;
    logic       cnt_inc;
    logic [2:0] cur_lamp, nxt_lamp;
    logic [8:0] cur_min, cur_max;
    state_t     adv_state;
    logic       legal;

    assign legal     = (lights == LAMP_RED) || (lights == LAMP_GRN) || (lights == LAMP_YEL);
    assign dwell_inc = (dwell == 8'hFF) ? 8'hFF : dwell + 8'd1;

    always_comb begin
        cur_lamp  = LAMP_RED;
        nxt_lamp  = LAMP_GRN;
        cur_min   = R_MIN;
        cur_max   = R_MAX;
        adv_state = GREEN;
        case (state)
            GREEN: begin
                cur_lamp  = LAMP_GRN;
                nxt_lamp  = LAMP_YEL;
                cur_min   = G_MIN;
                cur_max   = G_MAX;
                adv_state = YELLOW;
            end
            YELLOW: begin
                cur_lamp  = LAMP_YEL;
                nxt_lamp  = LAMP_RED;
                cur_min   = Y_MIN;
                cur_max   = Y_MAX;
                adv_state = RED;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        dwell_nxt     = dwell;
        first_red_nxt = first_red;
        fault         = 1'b0;
        code          = 3'd0;
        cnt_inc       = 1'b0;
        if (state == SYNC) begin
            dwell_nxt = 8'd0;
            // prev is cleared by reset, so a red first sample also locks here
            if (lights == LAMP_RED && prev != LAMP_RED) begin
                state_nxt     = RED;
                dwell_nxt     = 8'd1;
                first_red_nxt = 1'b1;
            end
        end else begin
            if (!legal) begin
                fault = 1'b1;
                code  = CODE_ILLEGAL;
            end else if (lights == cur_lamp) begin
                dwell_nxt = dwell_inc;
                if ({1'b0, dwell_inc} > cur_max) begin
                    fault = 1'b1;
                    code  = CODE_LONG;
                end
            end else if (lights == nxt_lamp) begin
                if ({1'b0, dwell} < cur_min && !(state == RED && first_red)) begin
                    fault = 1'b1;
                    code  = CODE_SHORT;
                end else begin
                    state_nxt     = adv_state;
                    dwell_nxt     = 8'd1;
                    first_red_nxt = 1'b0;
                    cnt_inc       = (state == YELLOW);
                end
            end else begin
                fault = 1'b1;
                code  = CODE_ORDER;
            end
            if (fault) begin
                state_nxt     = SYNC;
                dwell_nxt     = 8'd0;
                first_red_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            dwell      <= 8'd0;
            first_red  <= 1'b0;
            prev       <= 3'b000;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            err_sticky <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            dwell     <= dwell_nxt;
            first_red <= first_red_nxt;
            prev      <= lights;
            locked    <= (state_nxt != SYNC);
            err       <= fault;
            if (fault) begin
                err_code   <= code;
                err_sticky <= 1'b1;
            end
            if (cnt_inc && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign phase = state;

endmodule
